// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or load a bubble.
module if_id_reg #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A00000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  pc_plus4,
    output logic [INSTR_W-1:0] q_instr,
    output logic [ADDR_W-1:0]  q_pc,
    output logic [ADDR_W-1:0]  q_pc_plus4,
    output logic               q_valid
);
    // bubble wins over load; neither asserted means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instr    <= NOP_INSTR;
            q_pc       <= '0;
            q_pc_plus4 <= '0;
            q_valid    <= 1'b0;
        end else if (bubble) begin
            q_instr    <= NOP_INSTR;
            q_pc       <= '0;
            q_pc_plus4 <= '0;
            q_valid    <= 1'b0;
        end else if (load) begin
            q_instr    <= instr;
            q_pc       <= pc;
            q_pc_plus4 <= pc_plus4;
            q_valid    <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control and IF/ID register.
// Define FETCH_PERF_EN to add saturating fetch/stall performance counters.
module fetch_stage import fetch_pkg::*; #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
    parameter int INSTR_W = fetch_pkg::INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  PC_RESET  = '0,
    parameter logic [ADDR_W:0]    PC_LIMIT  = 68,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus4,
    output logic               if_id_valid,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);
    state_e            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_plus4, tgt;
    logic              load, bubble;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign tgt       = branch_target & ~ADDR_W'(3);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= PC_RESET;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        bubble     = 1'b0;
        case (state)
            BOOT: begin
                bubble     = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_next = tgt;
                    bubble  = 1'b1;
                end else if (stall) begin
                    bubble = flush;
                end else if (flush) begin
                    pc_next = pc_plus4;
                    bubble  = 1'b1;
                end else if ({1'b0, pc} >= PC_LIMIT) begin
                    bubble     = 1'b1;
                    state_next = HALT;
                end else begin
                    load    = 1'b1;
                    pc_next = pc_plus4;
                end
            end
            HALT: begin
                // a late branch from an older instruction can still restart fetch
                bubble = 1'b1;
                if (branch_taken && ({1'b0, tgt} < PC_LIMIT)) begin
                    pc_next    = tgt;
                    state_next = RUN;
                end
            end
            default: begin
                bubble     = 1'b1;
                state_next = BOOT;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bubble     (bubble),
        .instr      (imem_instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .q_instr    (if_id_instr),
        .q_pc       (if_id_pc),
        .q_pc_plus4 (if_id_pc_plus4),
        .q_valid    (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (state == RUN && stall && !branch_taken && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif
endmodule
